fsm_control_param: RTL and testbench

Parametrised flow-control state machine for the switch datapath. Generalises the fixed five-FIFO controller to NUM_FIFOS FIFOs with TH_W-bit thresholds each. Adds threshold range checking, a sticky per-FIFO error vector with explicit clear, and idle detection that requires a configurable run of empty cycles. Sits between the configuration source and the FIFO bank: it distributes the captured thresholds (umbrales_I) and reports active, idle and error status.

---
 rtl/fsm_control_param.sv | 116 +++++++++++
 tb/tb_fsm_control_param.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fsm_control_param.sv
// Parametrised flow-control FSM: captures per-FIFO thresholds, range-checks them,
// tracks sticky FIFO errors and detects idle after a run of all-empty cycles.
module fsm_control_param #(
    parameter int NUM_FIFOS = 5,
    parameter int TH_W      = 4,
    parameter int MAX_TH    = 12,
    parameter int IDLE_CNT  = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      init,
    input  logic [NUM_FIFOS*TH_W-1:0] umbral_in,
    input  logic [NUM_FIFOS-1:0]      FIFO_error,
    input  logic [NUM_FIFOS-1:0]      FIFO_empty,
    input  logic                      err_clear,
    output logic [NUM_FIFOS*TH_W-1:0] umbrales_I,
    output logic                      active,
    output logic                      idle,
    output logic [NUM_FIFOS-1:0]      error,
    output logic [2:0]                state
);

    localparam logic [2:0] RESET  = 3'd0;
    localparam logic [2:0] INIT   = 3'd1;
    localparam logic [2:0] IDLE   = 3'd2;
    localparam logic [2:0] ACTIVE = 3'd3;
    localparam logic [2:0] ERROR  = 3'd4;

    localparam int CNT_W = $clog2(IDLE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_CNT - 1);
    localparam logic [TH_W-1:0]  MAX_V    = TH_W'(MAX_TH);

    logic [CNT_W-1:0]          cnt, cnt_n;
    logic [2:0]                state_n;
    logic [NUM_FIFOS-1:0]      err_n;
    logic [NUM_FIFOS-1:0]      over;
    logic [NUM_FIFOS*TH_W-1:0] umb_n;

    always_comb begin
        over = '0;
        for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
            over[i] = (umbral_in[i*TH_W +: TH_W] > MAX_V);
        end
    end

    always_comb begin
        state_n = state;
        err_n   = error;
        cnt_n   = '0;
        umb_n   = (state == INIT) ? umbral_in : umbrales_I;

        if (state == RESET) begin
            state_n = INIT;
        end else if (|FIFO_error) begin
            // In ERROR an explicit clear wins over accumulation, then new errors land.
            state_n = ERROR;
            err_n   = (state == ERROR && err_clear) ? FIFO_error : (error | FIFO_error);
        end else begin
            case (state)
                INIT: begin
                    if (!init) begin
                        if (|over) begin
                            state_n = ERROR;
                            err_n   = error | over;
                        end else begin
                            state_n = ACTIVE;
                        end
                    end
                end
                ACTIVE: begin
                    if (init) begin
                        state_n = INIT;
                    end else if (&FIFO_empty) begin
                        if (cnt == CNT_LAST) begin
                            state_n = IDLE;
                        end else begin
                            cnt_n = cnt + CNT_W'(1);
                        end
                    end
                end
                IDLE: begin
                    if (init) begin
                        state_n = INIT;
                    end else if (!(&FIFO_empty)) begin
                        state_n = ACTIVE;
                    end
                end
                ERROR: begin
                    if (err_clear) begin
                        state_n = INIT;
                        err_n   = '0;
                    end
                end
                default: state_n = RESET;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RESET;
            error      <= '0;
            umbrales_I <= '0;
            cnt        <= '0;
        end else begin
            state      <= state_n;
            error      <= err_n;
            umbrales_I <= umb_n;
            cnt        <= cnt_n;
        end
    end

    assign active = (state == ACTIVE);
    assign idle   = (state == IDLE);

endmodule

// File: tb/tb_fsm_control_param.sv
// Directed bench for fsm_control_param: default 5-FIFO instance plus a
// 2-FIFO / IDLE_CNT=1 instance, checked through an expected-result queue.
module tb_fsm_control_param;

    typedef struct packed {
        logic [2:0]  st;
        logic [4:0]  err;
        logic [19:0] umb;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset, a_init, a_clr;
    logic [19:0] a_umb_in, a_umb;
    logic [4:0]  a_ferr, a_empty, a_err;
    logic        a_active, a_idle;
    logic [2:0]  a_state;

    logic        b_reset, b_init, b_clr;
    logic [3:0]  b_umb_in, b_umb;
    logic [1:0]  b_ferr, b_empty, b_err;
    logic        b_active, b_idle;
    logic [2:0]  b_state;

    fsm_control_param dut_a (
        .clk(clk), .reset(a_reset), .init(a_init), .umbral_in(a_umb_in),
        .FIFO_error(a_ferr), .FIFO_empty(a_empty), .err_clear(a_clr),
        .umbrales_I(a_umb), .active(a_active), .idle(a_idle),
        .error(a_err), .state(a_state)
    );

    fsm_control_param #(.NUM_FIFOS(2), .TH_W(2), .MAX_TH(3), .IDLE_CNT(1)) dut_b (
        .clk(clk), .reset(b_reset), .init(b_init), .umbral_in(b_umb_in),
        .FIFO_error(b_ferr), .FIFO_empty(b_empty), .err_clear(b_clr),
        .umbrales_I(b_umb), .active(b_active), .idle(b_idle),
        .error(b_err), .state(b_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_a(input string tag);
        exp_t e;
        if (q_a.size() == 0) begin
            chk({tag, "_queue_a"}, 32'd0, 32'd1);
            return;
        end
        e = q_a.pop_front();
        chk({tag, "_state"},  {29'd0, a_state}, {29'd0, e.st});
        chk({tag, "_active"}, {31'd0, a_active}, {31'd0, e.st == 3'd3});
        chk({tag, "_idle"},   {31'd0, a_idle},   {31'd0, e.st == 3'd2});
        chk({tag, "_error"},  {27'd0, a_err},    {27'd0, e.err});
        chk({tag, "_umb"},    {12'd0, a_umb},    {12'd0, e.umb});
    endtask

    task automatic cmp_b(input string tag);
        exp_t e;
        if (q_b.size() == 0) begin
            chk({tag, "_queue_b"}, 32'd0, 32'd1);
            return;
        end
        e = q_b.pop_front();
        chk({tag, "_state"},  {29'd0, b_state}, {29'd0, e.st});
        chk({tag, "_active"}, {31'd0, b_active}, {31'd0, e.st == 3'd3});
        chk({tag, "_idle"},   {31'd0, b_idle},   {31'd0, e.st == 3'd2});
        chk({tag, "_error"},  {27'd0, 3'd0, b_err}, {27'd0, e.err});
        chk({tag, "_umb"},    {12'd0, 16'd0, b_umb}, {12'd0, e.umb});
    endtask

    // push expectation, clock one edge, sample 1 time unit later
    task automatic cyc_a(input string tag, input logic [2:0] st, input logic [4:0] err,
                         input logic [19:0] umb);
        q_a.push_back('{st: st, err: err, umb: umb});
        @(posedge clk);
        #1;
        cmp_a(tag);
    endtask

    task automatic cyc_b(input string tag, input logic [2:0] st, input logic [1:0] err,
                         input logic [3:0] umb);
        q_b.push_back('{st: st, err: {3'd0, err}, umb: {16'd0, umb}});
        @(posedge clk);
        #1;
        cmp_b(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        a_reset = 1'b0; a_init = 1'b0; a_clr = 1'b0;
        a_umb_in = '0; a_ferr = '0; a_empty = '0;
        b_reset = 1'b0; b_init = 1'b0; b_clr = 1'b0;
        b_umb_in = '0; b_ferr = '0; b_empty = '0;

        #3;
        q_a.push_back('{st: 3'd0, err: 5'd0, umb: 20'd0});
        cmp_a("por");

        @(posedge clk); #1;
        a_reset = 1'b1;
        cyc_a("rel", 3'd1, 5'd0, 20'h00000);
        a_init = 1'b1; a_umb_in = 20'h11111;
        cyc_a("cfg", 3'd1, 5'd0, 20'h11111);
        a_init = 1'b0;
        cyc_a("go_act", 3'd3, 5'd0, 20'h11111);
        a_umb_in = 20'hFFFFF;
        cyc_a("hold_umb", 3'd3, 5'd0, 20'h11111);

        a_empty = 5'b11111;
        cyc_a("emp1", 3'd3, 5'd0, 20'h11111);
        cyc_a("emp2", 3'd3, 5'd0, 20'h11111);
        a_empty = 5'b11110;
        cyc_a("emp_brk", 3'd3, 5'd0, 20'h11111);
        a_empty = 5'b11111;
        cyc_a("emp_r1", 3'd3, 5'd0, 20'h11111);
        cyc_a("emp_r2", 3'd3, 5'd0, 20'h11111);
        cyc_a("to_idle", 3'd2, 5'd0, 20'h11111);
        a_empty = 5'b11011;
        cyc_a("idle_exit", 3'd3, 5'd0, 20'h11111);

        // asynchronous reset between edges while ACTIVE
        #2;
        a_reset = 1'b0;
        #1;
        q_a.push_back('{st: 3'd0, err: 5'd0, umb: 20'd0});
        cmp_a("async_rst");
        a_reset = 1'b1;
        cyc_a("rst_init", 3'd1, 5'd0, 20'h00000);

        a_init = 1'b1; a_umb_in = 20'h0D111;
        cyc_a("cfg_bad", 3'd1, 5'd0, 20'h0D111);
        a_init = 1'b0;
        cyc_a("range_err", 3'd4, 5'b01000, 20'h0D111);

        a_clr = 1'b1;
        cyc_a("clr1", 3'd1, 5'd0, 20'h0D111);
        a_clr = 1'b0; a_umb_in = 20'h11111; a_empty = 5'b00000;
        cyc_a("re_act", 3'd3, 5'd0, 20'h11111);

        a_ferr = 5'b00100;
        cyc_a("ferr1", 3'd4, 5'b00100, 20'h11111);
        a_ferr = 5'b00000;
        cyc_a("sticky", 3'd4, 5'b00100, 20'h11111);
        a_ferr = 5'b00001;
        cyc_a("ferr2", 3'd4, 5'b00101, 20'h11111);
        a_ferr = 5'b00000; a_init = 1'b1;
        cyc_a("init_ign", 3'd4, 5'b00101, 20'h11111);
        a_init = 1'b0; a_clr = 1'b1; a_ferr = 5'b10000;
        cyc_a("clr_set", 3'd4, 5'b10000, 20'h11111);
        a_ferr = 5'b00000;
        cyc_a("clr2", 3'd1, 5'd0, 20'h11111);
        a_clr = 1'b0;
        cyc_a("back_act", 3'd3, 5'd0, 20'h11111);

        b_reset = 1'b1;
        cyc_b("b_rel", 3'd1, 2'd0, 4'h0);
        b_init = 1'b1; b_umb_in = 4'b1110;
        cyc_b("b_cfg", 3'd1, 2'd0, 4'hE);
        b_init = 1'b0; b_umb_in = 4'b0101;
        cyc_b("b_act", 3'd3, 2'd0, 4'h5);
        b_empty = 2'b11;
        cyc_b("b_idle", 3'd2, 2'd0, 4'h5);
        b_empty = 2'b01;
        cyc_b("b_exit", 3'd3, 2'd0, 4'h5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
